// File: rtl/ex_stage_if.sv
// EX-stage port bundle: ID-to-EX inputs, EX-to-MEM / forwarding / data-SRAM outputs.
// The master side drives the pipeline inputs; the slave side is the execute stage.
interface ex_stage_if;
    localparam int unsigned ID_BUS_W  = 159;
    localparam int unsigned MEM_BUS_W = 141;
    localparam int unsigned FWD_BUS_W = 38;

    logic [5:0]           stall;
    logic [ID_BUS_W-1:0]  id_to_ex_bus;
    logic [1:0]           div_op;
    logic [MEM_BUS_W-1:0] ex_to_mem_bus;
    logic [FWD_BUS_W-1:0] ex_to_id_bus;
    logic                 data_sram_en;
    logic [3:0]           data_sram_wen;
    logic [31:0]          data_sram_addr;
    logic [31:0]          data_sram_wdata;
    logic                 stallreq_for_ex;

    modport master (
        output stall, id_to_ex_bus, div_op,
        input  ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );

    modport slave (
        input  stall, id_to_ex_bus, div_op,
        output ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, operand select, 12-op ALU, data-SRAM request,
// EX->ID forwarding and a multi-cycle restoring divider that stalls the front end.
module ex_stage #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);
    localparam int unsigned ID_BUS_W = 159;
    localparam int unsigned CNT_W    = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    logic [ID_BUS_W-1:0] id_q;
    logic [1:0]          div_op_q;
    logic                bubble;

    assign bubble = bus.stall[2] & ~bus.stall[3];

    // ID/EX pipeline register: bubble, capture or hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q     <= '0;
            div_op_q <= '0;
        end else if (bubble) begin
            id_q     <= '0;
            div_op_q <= '0;
        end else if (!bus.stall[2]) begin
            id_q     <= bus.id_to_ex_bus;
            div_op_q <= bus.div_op;
        end
    end

    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2, ram_wen;
    logic        ram_en, rf_we, sel_rf_res;
    logic [4:0]  rf_waddr;

    assign pc         = id_q[158:127];
    assign inst       = id_q[126:95];
    assign alu_op     = id_q[94:83];
    assign sel_src1   = id_q[82:80];
    assign sel_src2   = id_q[79:76];
    assign ram_en     = id_q[75];
    assign ram_wen    = id_q[74:71];
    assign rf_we      = id_q[70];
    assign rf_waddr   = id_q[69:65];
    assign sel_rf_res = id_q[64];
    assign rdata1     = id_q[63:32];
    assign rdata2     = id_q[31:0];

    logic [31:0] src1, src2, alu_result;

    assign src1 = ({32{sel_src1[0]}} & rdata1)
                | ({32{sel_src1[1]}} & pc)
                | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    assign src2 = ({32{sel_src2[0]}} & rdata2)
                | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
                | ({32{sel_src2[2]}} & 32'd8)
                | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});

    // One-hot ALU: each selected op ORs its result in; no op selected gives 0
    always_comb begin
        alu_result = '0;
        if (alu_op[11]) alu_result = alu_result | (src1 + src2);
        if (alu_op[10]) alu_result = alu_result | (src1 - src2);
        if (alu_op[9])  alu_result = alu_result | {31'b0, $signed(src1) < $signed(src2)};
        if (alu_op[8])  alu_result = alu_result | {31'b0, src1 < src2};
        if (alu_op[7])  alu_result = alu_result | (src1 & src2);
        if (alu_op[6])  alu_result = alu_result | ~(src1 | src2);
        if (alu_op[5])  alu_result = alu_result | (src1 | src2);
        if (alu_op[4])  alu_result = alu_result | (src1 ^ src2);
        if (alu_op[3])  alu_result = alu_result | (src2 << src1[4:0]);
        if (alu_op[2])  alu_result = alu_result | (src2 >> src1[4:0]);
        if (alu_op[1])  alu_result = alu_result | 32'($signed(src2) >>> src1[4:0]);
        if (alu_op[0])  alu_result = alu_result | {src2[15:0], 16'b0};
    end

    div_state_e state_q, state_d;
    logic       stall_req;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // DONE holds until EX is released so a held divide is never restarted
    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_op_q[1]) begin
                    stall_req = 1'b1;
                    if (!bubble) state_d = BUSY;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (bubble)                  state_d = IDLE;
                else if (cnt_q == LAST_STEP) state_d = DONE;
            end
            DONE: begin
                if (!bus.stall[2]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [31:0] quo_q, rem_q, dsr_q, mag1, mag2;
    logic        neg_quo_q, neg_rem_q, dz_q, div_signed, step_ge;
    logic [32:0] rem_shift, rem_diff;

    assign div_signed = div_op_q[0];
    assign mag1       = (div_signed && rdata1[31]) ? (~rdata1 + 32'd1) : rdata1;
    assign mag2       = (div_signed && rdata2[31]) ? (~rdata2 + 32'd1) : rdata2;
    assign rem_shift  = {rem_q, quo_q[31]};
    assign rem_diff   = rem_shift - {1'b0, dsr_q};
    assign step_ge    = rem_shift >= {1'b0, dsr_q};

    // Restoring divider: dividend shifts out of quo_q while quotient bits shift in
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (state_q == IDLE && state_d == BUSY) begin
            quo_q     <= mag1;
            rem_q     <= '0;
            dsr_q     <= mag2;
            cnt_q     <= '0;
            neg_quo_q <= div_signed & (rdata1[31] ^ rdata2[31]);
            neg_rem_q <= div_signed & rdata1[31];
            dz_q      <= (rdata2 == 32'd0);
        end else if (state_q == BUSY) begin
            rem_q <= step_ge ? rem_diff[31:0] : rem_shift[31:0];
            quo_q <= {quo_q[30:0], step_ge};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    logic [31:0] quo_res, rem_res;
    logic        hilo_we;
    logic [63:0] hilo;

    assign quo_res = dz_q ? 32'hFFFF_FFFF : (neg_quo_q ? (~quo_q + 32'd1) : quo_q);
    assign rem_res = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    assign hilo_we = (state_q == DONE);
    assign hilo    = hilo_we ? {rem_res, quo_res} : 64'd0;

    assign bus.ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr,
                                  alu_result, hilo_we, hilo};
    assign bus.ex_to_id_bus    = {rf_we & ~sel_rf_res, rf_waddr, alu_result};
    assign bus.data_sram_en    = ram_en & ~stall_req;
    assign bus.data_sram_wen   = stall_req ? 4'b0 : ram_wen;
    assign bus.data_sram_addr  = alu_result;
    assign bus.data_sram_wdata = rdata2;
    assign bus.stallreq_for_ex = stall_req;

    logic unused_bits;
    assign unused_bits = ^{inst[31:16], bus.stall[5:4], bus.stall[1:0], rem_diff[32]};
endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage: a behavioural model predicts every cycle,
// a monitor pops predictions at the falling edge and compares against the DUT.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if bus_if();
    ex_stage #(.DIV_CYCLES(32)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200,
                            OP_SLTU = 12'h100, OP_AND = 12'h080, OP_NOR = 12'h040,
                            OP_OR = 12'h020, OP_XOR = 12'h010, OP_SLL = 12'h008,
                            OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;
    localparam logic [5:0] ST_RUN = 6'b000000, ST_HOLD = 6'b001111, ST_BUBBLE = 6'b000111;

    typedef struct packed {
        logic [140:0] mem;
        logic [37:0]  fwd;
        logic         en;
        logic [3:0]   wen;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic         sreq;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: instruction currently in EX, remaining stall cycles of a divide, and its result
    logic [158:0] m_bus;
    int           stall_left;
    bit           ready;
    logic [63:0]  m_hilo;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [158:0] mk_bus(input logic [31:0] pc, input logic [31:0] inst,
            input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
            input logic en, input logic [3:0] wen, input logic rfwe, input logic [4:0] waddr,
            input logic selres, input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, en, wen, rfwe, waddr, selres, r1, r2};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [158:0] b);
        logic [31:0] a, c, imm;
        imm = {16'b0, b[110:95]};
        case (b[82:80])
            3'b001:  a = b[63:32];
            3'b010:  a = b[158:127];
            3'b100:  a = {27'b0, b[105:101]};
            default: a = 32'd0;
        endcase
        case (b[79:76])
            4'b0001: c = b[31:0];
            4'b0010: c = imm[15] ? (imm | 32'hFFFF_0000) : imm;
            4'b0100: c = 32'd8;
            4'b1000: c = imm;
            default: c = 32'd0;
        endcase
        case (b[94:83])
            OP_ADD:  return a + c;
            OP_SUB:  return a - c;
            OP_SLT:  return ($signed(a) < $signed(c)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < c) ? 32'd1 : 32'd0;
            OP_AND:  return a & c;
            OP_NOR:  return ~(a | c);
            OP_OR:   return a | c;
            OP_XOR:  return a ^ c;
            OP_SLL:  return c << a[4:0];
            OP_SRL:  return c >> a[4:0];
            OP_SRA:  return 32'($signed(c) >>> a[4:0]);
            OP_LUI:  return {c[15:0], 16'h0};
            default: return 32'd0;
        endcase
    endfunction

    // {remainder, quotient} straight from the arithmetic rules
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
        return {r, q};
    endfunction

    task automatic model_clear();
        m_bus = '0; stall_left = 0; ready = 0; m_hilo = '0;
    endtask

    task automatic model_step(input logic [5:0] s, input logic [158:0] b, input logic [1:0] d);
        bit bub;
        bub = s[2] & ~s[3];
        if (stall_left > 0) begin
            if (bub) stall_left = 0;
            else begin
                stall_left--;
                if (stall_left == 0) ready = 1;
            end
        end else if (ready && !s[2]) begin
            ready = 0;
        end
        if (bub) m_bus = '0;
        else if (!s[2]) begin
            m_bus = b;
            if (d[1]) begin
                stall_left = 33;
                m_hilo = ref_div(b[63:32], b[31:0], d[0]);
            end
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        logic [31:0] alu;
        alu    = ref_alu(m_bus);
        e.sreq = (stall_left > 0);
        e.mem  = {m_bus[158:127], m_bus[75], m_bus[74:71], m_bus[64], m_bus[70], m_bus[69:65],
                  alu, ready, ready ? m_hilo : 64'd0};
        e.fwd  = {m_bus[70] & ~m_bus[64], m_bus[69:65], alu};
        e.en   = m_bus[75] & ~e.sreq;
        e.wen  = e.sreq ? 4'd0 : m_bus[74:71];
        e.addr = alu;
        e.wdata = m_bus[31:0];
        return e;
    endfunction

    task automatic cycle(input logic [5:0] s, input logic [158:0] b, input logic [1:0] d);
        bus_if.stall = s; bus_if.id_to_ex_bus = b; bus_if.div_op = d;
        @(posedge clk); #1;
        model_step(s, b, d);
        exp_q.push_back(model_exp());
    endtask

    task automatic do_reset(input int n);
        @(negedge clk); #1;
        rst = 1'b0;
        bus_if.stall = '0; bus_if.id_to_ex_bus = '0; bus_if.div_op = '0;
        model_clear();
        repeat (n) begin
            @(posedge clk); #1;
            exp_q.push_back(model_exp());
        end
        rst = 1'b1;
    endtask

    // Monitor: compares every cycle the DUT presents against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ex_to_mem_bus",   bus_if.ex_to_mem_bus,   e.mem);
                chk("ex_to_id_bus",    bus_if.ex_to_id_bus,    e.fwd);
                chk("data_sram_en",    bus_if.data_sram_en,    e.en);
                chk("data_sram_wen",   bus_if.data_sram_wen,   e.wen);
                chk("data_sram_addr",  bus_if.data_sram_addr,  e.addr);
                chk("data_sram_wdata", bus_if.data_sram_wdata, e.wdata);
                chk("stallreq_for_ex", bus_if.stallreq_for_ex, e.sreq);
            end
        end
    end

    function automatic logic [31:0] pick_word();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [158:0] rand_bus();
        int k1, k2, k3;
        logic [11:0] op;
        logic [2:0]  s1;
        logic [3:0]  s2;
        k1 = $urandom_range(0, 12); k2 = $urandom_range(0, 3); k3 = $urandom_range(0, 4);
        op = (k1 == 12) ? 12'd0 : (12'd1 << k1);
        s1 = (k2 == 3) ? 3'd0 : (3'd1 << k2);
        s2 = (k3 == 4) ? 4'd0 : (4'd1 << k3);
        return mk_bus($urandom, $urandom, op, s1, s2, 1'($urandom), 4'($urandom),
                      1'($urandom), 5'($urandom), 1'($urandom), pick_word(), pick_word());
    endfunction

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] want);
        logic [158:0] bd;
        int n;
        bd = mk_bus(32'h0040_0100, 32'd0, 12'd0, 3'b001, 4'b0001, 1'b0, 4'd0, 1'b0, 5'd0,
                    1'b0, a, b);
        cycle(ST_RUN, bd, {1'b1, sgn});
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (!bus_if.stallreq_for_ex) break;
            n++;
            cycle(ST_HOLD, bd, {1'b1, sgn});
        end
        chk({name, "_stall_cycles"}, 160'(n), 160'd33);
        chk({name, "_hilo_we"}, bus_if.ex_to_mem_bus[64], 1'b1);
        chk({name, "_hilo"}, bus_if.ex_to_mem_bus[63:0], want);
    endtask

    initial begin
        logic [158:0] b;
        logic [1:0]   d;
        logic [5:0]   s;
        rst = 1'b0;
        model_clear();
        do_reset(3);
        for (int i = 0; i < 8; i++) cycle(ST_RUN, rand_bus(), 2'b00);
        do_reset(2);

        // addiu: rdata1 5 + sign-extended 0xFFFF
        cycle(ST_RUN, mk_bus(32'h0040_0000, 32'h0000_FFFF, OP_ADD, 3'b001, 4'b0010, 1'b0, 4'd0,
                             1'b1, 5'd3, 1'b0, 32'd5, 32'd0), 2'b00);
        @(negedge clk); #1;
        chk("addiu_alu", bus_if.ex_to_mem_bus[96:65], 32'd4);
        chk("addiu_rf_we", bus_if.ex_to_mem_bus[102], 1'b1);

        cycle(ST_RUN, mk_bus(32'h0040_0010, 32'd0, OP_ADD, 3'b010, 4'b0100, 1'b0, 4'd0,
                             1'b1, 5'd31, 1'b0, 32'd0, 32'd0), 2'b00);
        @(negedge clk); #1;
        chk("jal_fwd", bus_if.ex_to_id_bus, {1'b1, 5'd31, 32'h0040_0018});

        cycle(ST_RUN, mk_bus(32'h0040_0014, 32'h0000_0004, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF,
                             1'b0, 5'd0, 1'b0, 32'h1000, 32'hDEAD_BEEF), 2'b00);
        @(negedge clk); #1;
        chk("store_en", bus_if.data_sram_en, 1'b1);
        chk("store_addr", bus_if.data_sram_addr, 32'h1004);
        chk("store_wdata", bus_if.data_sram_wdata, 32'hDEAD_BEEF);
        chk("store_wen", bus_if.data_sram_wen, 4'hF);

        cycle(ST_RUN, mk_bus(32'h0040_0018, 32'h0000_0008, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0,
                             1'b1, 5'd5, 1'b1, 32'h1000, 32'd0), 2'b00);
        @(negedge clk); #1;
        chk("load_fwd_we", bus_if.ex_to_id_bus[37], 1'b0);

        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        cycle(ST_RUN, '0, 2'b00);

        run_div("divu_by0", 32'h10, 32'd0, 1'b0, {32'h10, 32'hFFFF_FFFF});
        for (int k = 0; k < 3; k++) begin
            cycle(ST_HOLD, bus_if.id_to_ex_bus, 2'b10);
            @(negedge clk); #1;
            chk("done_hold_hilo_we", bus_if.ex_to_mem_bus[64], 1'b1);
            chk("done_hold_stallreq", bus_if.stallreq_for_ex, 1'b0);
        end
        cycle(ST_RUN, '0, 2'b00);
        @(negedge clk); #1;
        chk("after_done_hilo_we", bus_if.ex_to_mem_bus[64], 1'b0);
        chk("after_done_stallreq", bus_if.stallreq_for_ex, 1'b0);

        run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000});
        cycle(ST_RUN, '0, 2'b00);

        cycle(ST_RUN, rand_bus(), 2'b00);
        cycle(6'b000100, rand_bus(), 2'b00);
        @(negedge clk); #1;
        chk("bubble_mem_bus", bus_if.ex_to_mem_bus, 141'd0);
        chk("bubble_fwd_bus", bus_if.ex_to_id_bus, 38'd0);

        // Reset in the middle of a divide
        b = mk_bus(32'h0040_0200, 32'd0, 12'd0, 3'b001, 4'b0001, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0,
                   32'd100, 32'd7);
        cycle(ST_RUN, b, 2'b11);
        repeat (10) cycle(ST_HOLD, b, 2'b11);
        do_reset(2);
        for (int k = 0; k < 40; k++) begin
            cycle(ST_RUN, '0, 2'b00);
            @(negedge clk); #1;
            chk("abort_hilo_we", bus_if.ex_to_mem_bus[64], 1'b0);
            chk("abort_stallreq", bus_if.stallreq_for_ex, 1'b0);
        end

        // Random traffic with a model-driven stall controller
        for (int i = 0; i < 1500; i++) begin
            if (stall_left > 0)
                s = ($urandom_range(0, 99) == 0) ? ST_BUBBLE : ST_HOLD;
            else begin
                case ($urandom_range(0, 9))
                    7, 8:    s = ST_HOLD;
                    9:       s = ST_BUBBLE;
                    default: s = ST_RUN;
                endcase
            end
            d = ($urandom_range(0, 5) == 0) ? {1'b1, 1'($urandom)} : 2'b00;
            cycle(s, rand_bus(), d);
        end
        cycle(ST_RUN, '0, 2'b00);
        @(negedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the five-stage MIPS pipeline; consumes the 159-bit ID-to-EX bus and produces the 141-bit EX-to-MEM bus.
- Holds the ID/EX pipeline register and selects ALU operands.
- Runs the 12-op ALU and drives data-SRAM request signals.
- Contains a 32-iteration radix-2 divider for DIV/DIVU that stalls the pipeline while busy, and returns a forwarding bus to ID.

Parameters:
- DIV_CYCLES, 32, number of BUSY iterations of the divider (fixed to operand width).

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  6  pipeline stall vector; bit 2 = EX, bit 3 = MEM; 1 = Stop
- id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}
- div_op  in  2  from ID, aligned with id_to_ex_bus; [1] = divide, [0] = signed
- ex_to_mem_bus  out  141  {pc[140:109], data_ram_en[108], data_ram_wen[107:104], sel_rf_res[103], rf_we[102], rf_waddr[101:97], alu_result[96:65], hilo_we[64], hilo[63:0] = {remainder, quotient}}
- ex_to_id_bus  out  38  {we, waddr[4:0], wdata[31:0]} forwarding
- data_sram_en  out  1  data RAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  = alu_result
- data_sram_wdata  out  32  = rdata2
- stallreq_for_ex  out  1  request to freeze stages 0..2

Behaviour:
- Pipeline register, updated on each rising edge:
  - stall[2]=Stop and stall[3]=NoStop: load all-zero bubble.
  - Otherwise stall[2]=NoStop: capture id_to_ex_bus and div_op.
  - Otherwise: hold.
- Reset (rst=0, asynchronous): pipeline register cleared, FSM = IDLE, quotient/remainder regs = 0.
- Consequently all outputs are 0 during and after reset until the first capture, including stallreq_for_ex.
- src1 selection:
  - [0] rdata1
  - [1] pc
  - [2] {27'b0, inst[10:6]}
  - none set: 0
- src2 selection:
  - [0] rdata2
  - [1] sign-extended inst[15:0]
  - [2] 32'd8
  - [3] zero-extended inst[15:0]
  - none set: 0
- alu_op is one-hot {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}:
  - add/sub: 32-bit, wrapping, no overflow trap.
  - slt: signed compare; sltu: unsigned compare; both give 32'd1 or 32'd0.
  - sll/srl/sra: shift src2 by src1[4:0].
  - lui: {src2[15:0], 16'b0}.
  - No op bit set: result 0.
- ALU path is purely combinational from the pipeline register; latency 0 cycles within EX.
- Data SRAM:
  - data_sram_en = data_ram_en; data_sram_wen = data_ram_wen; address and write data are issued in the same cycle.
  - While stallreq_for_ex=1, data_sram_en=0 and data_sram_wen=0.
- Forwarding:
  - ex_to_id_bus.we = rf_we & ~sel_rf_res; loads are not forwarded from EX.
  - ex_to_id_bus.waddr = rf_waddr; ex_to_id_bus.wdata = alu_result.
- Divider FSM has three states: IDLE, BUSY, DONE.
  - IDLE: if div_op[1]=1, assert stallreq_for_ex combinationally. On the next edge, latch operands (magnitudes if signed), clear the iteration counter, go BUSY.
  - BUSY: one restoring-division step per cycle; stallreq_for_ex=1. After DIV_CYCLES steps, go DONE.
  - DONE: stallreq_for_ex=0. ex_to_mem_bus.hilo_we=1 and hilo = {remainder, quotient}. Return to IDLE on the edge where stall[2]=NoStop; otherwise hold DONE so the same instruction is never re-divided.
  - Total stall per divide: 33 cycles; the result is visible in cycle 34.
- Signed correction:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- Divide by zero: same latency; quotient = 32'hFFFFFFFF, remainder = dividend.
- A bubble or reset arriving while the FSM is in BUSY aborts the divide: FSM goes to IDLE, hilo_we is never asserted.
- hilo_we=0 and hilo=0 whenever FSM is not DONE.

Test Plan:
- Reset low mid-stream -> every output 0; after release with stall=0, addiu rdata1=5, imm=0xFFFF -> alu_result 4, rf_we 1 in the same cycle.
- jal at pc 0x00400010 (src1=pc, src2=8, add, waddr 31) -> alu_result 0x00400018, ex_to_id_bus = {1, 31, 0x00400018}.
- Store: data_ram_en=1, wen=4'hF, rdata1=0x1000, imm=0x0004, rdata2=0xDEADBEEF -> sram en=1, addr 0x1004, wdata 0xDEADBEEF; load with sel_rf_res=1 -> ex_to_id_bus.we=0.
- DIV signed -7 / 2 -> stallreq high exactly 33 cycles; then hilo_we=1, quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIVU 0x10 / 0 -> quotient 0xFFFFFFFF, remainder 0x10; with stall[2] held Stop by MEM during DONE -> result stays for 3 extra cycles, no second divide.
- stall[2]=Stop, stall[3]=NoStop -> next cycle bus is all-zero bubble; assert rst mid-BUSY -> FSM IDLE, stallreq 0, hilo_we never 1.
